// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: bus width, default
// reset PC and NOP encoding, and the buffered {pc, inst} entry layout.
package fetch_unit_pkg;

    localparam int          INST_BUS         = 32;
    localparam logic [31:0] NOP_DEFAULT      = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_2000;

    typedef struct packed {
        logic [31:0]          pc;
        logic [INST_BUS-1:0]  inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO with synchronous flush; a push and pop in the same cycle
// are accepted even when full.
module fetch_fifo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            wr_ptr <= wr_ptr ^ do_push;
            rd_ptr <= rd_ptr ^ do_pop;
            count  <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // NOTE: storage is deliberately not reset; empty/count gate every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues sequential word fetches, pairs in-order responses
// with their PCs, buffers up to two instructions and drops stale responses.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0]         RESET_PC = RESET_PC_DEFAULT,
    parameter logic [INST_BUS-1:0] NOP_INST = NOP_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_i,
    input  logic                redirect_valid_i,
    input  logic [31:0]         redirect_pc_i,
    output logic                imem_req_o,
    output logic [31:0]         imem_addr_o,
    input  logic                imem_gnt_i,
    input  logic                imem_rvalid_i,
    input  logic [INST_BUS-1:0] imem_rdata_i,
    output logic                inst_valid_o,
    output logic [INST_BUS-1:0] inst_o,
    output logic [31:0]         pc_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_FLUSH
    } state_e;

    state_e       state_q, state_d;
    logic [31:0]  pc_q;
    logic [1:0]   out_cnt_q, out_cnt_d;
    logic [1:0]   drop_cnt_q, drop_cnt_d;
    logic [1:0]   fifo_count;
    logic [2:0]   in_flight;
    logic         grant, dropping, resp_keep, issue_ok;
    logic         inst_full, inst_empty, pend_full, pend_empty;
    logic [31:0]  pend_pc;
    fetch_entry_t push_entry, head_entry;

    assign grant      = imem_req_o & imem_gnt_i;
    assign dropping   = (drop_cnt_q != 2'd0);
    assign resp_keep  = imem_rvalid_i & ~dropping & ~redirect_valid_i & ~pend_empty;
    assign fifo_count = inst_full ? 2'd2 : (inst_empty ? 2'd0 : 2'd1);
    // Outstanding includes requests whose responses will be dropped.
    assign in_flight  = {1'b0, out_cnt_q} + {1'b0, fifo_count};
    assign out_cnt_d  = out_cnt_q + {1'b0, grant} - {1'b0, imem_rvalid_i};

    assign issue_ok    = (in_flight < 3'd2) & ~redirect_valid_i & ~pend_full;
    assign imem_req_o  = (state_q != ST_IDLE) & issue_ok;
    assign imem_addr_o = pc_q;

    // A redirect discards every request still in flight after this cycle.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (redirect_valid_i) begin
            drop_cnt_d = out_cnt_q - {1'b0, imem_rvalid_i};
        end else if (imem_rvalid_i && dropping) begin
            drop_cnt_d = drop_cnt_q - 2'd1;
        end
    end

    // NOTE: next-state gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = (drop_cnt_d != 2'd0) ? ST_FLUSH : ST_FETCH;
            ST_FETCH: if (redirect_valid_i && drop_cnt_d != 2'd0) state_d = ST_FLUSH;
            ST_FLUSH: if (drop_cnt_d == 2'd0) state_d = ST_FETCH;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Reset keeps counting pre-reset grants so their late responses are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= out_cnt_d;
        end else begin
            state_q    <= state_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            if (redirect_valid_i) begin
                pc_q <= redirect_pc_i & 32'hFFFF_FFFC;
            end else if (grant) begin
                pc_q <= pc_q + 32'd4;
            end
        end
    end

    fetch_fifo #(.WIDTH(32)) u_pend_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid_i),
        .push  (grant),
        .pop   (resp_keep),
        .din   (pc_q),
        .dout  (pend_pc),
        .full  (pend_full),
        .empty (pend_empty)
    );

    assign push_entry = '{pc: pend_pc, inst: imem_rdata_i};

    fetch_fifo #(.WIDTH($bits(fetch_entry_t))) u_inst_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid_i),
        .push  (resp_keep),
        .pop   (inst_valid_o & ~stall_i),
        .din   (push_entry),
        .dout  (head_entry),
        .full  (inst_full),
        .empty (inst_empty)
    );

    assign inst_valid_o = ~inst_empty;
    assign inst_o       = inst_valid_o ? head_entry.inst : NOP_INST;
    assign pc_o         = inst_valid_o ? head_entry.pc : 32'd0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic
// compared against a scoreboard of granted-but-undelivered PCs.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_2000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, stall_i, redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
    logic [31:0] imem_addr_o, imem_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o, pc_o;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk              (clk),
        .rst              (rst),
        .stall_i          (stall_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_gnt_i       (imem_gnt_i),
        .imem_rvalid_i    (imem_rvalid_i),
        .imem_rdata_i     (imem_rdata_i),
        .inst_valid_o     (inst_valid_o),
        .inst_o           (inst_o),
        .pc_o             (pc_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_0F0F;
    endfunction

    // stimulus controls
    logic        d_rst = 1'b1, d_stall = 1'b0, d_redir = 1'b0, d_gnt = 1'b1;
    logic [31:0] d_tgt = 32'd0;
    logic        rst_on_req = 1'b0, rst_hit = 1'b0;

    // memory model and reference state
    logic        last_grant = 1'b0;
    logic [31:0] last_addr  = 32'd0;
    logic [31:0] q[$];
    logic [31:0] exp_pc = RST_PC;

    // previous-cycle observations
    logic        p_valid = 1'b0, p_stall = 1'b0, p_redir = 1'b0, p_rst = 1'b1;
    logic [31:0] p_pc = 32'd0, p_inst = 32'd0;

    // current-cycle observations
    logic        o_req, o_valid, o_grant;
    logic [31:0] o_addr, o_pc, o_inst;

    task automatic step();
        @(negedge clk);
        rst              = d_rst;
        stall_i          = d_stall;
        redirect_valid_i = d_redir;
        redirect_pc_i    = d_tgt;
        imem_gnt_i       = d_gnt;
        imem_rvalid_i    = last_grant;
        imem_rdata_i     = last_grant ? mem_word(last_addr) : $urandom;
        #1;
        if (rst_on_req && imem_req_o && imem_gnt_i && !rst) begin
            rst        = 1'b1;
            rst_hit    = 1'b1;
            rst_on_req = 1'b0;
            #1;
        end
        o_req   = imem_req_o;
        o_addr  = imem_addr_o;
        o_valid = inst_valid_o;
        o_pc    = pc_o;
        o_inst  = inst_o;
        o_grant = imem_req_o & imem_gnt_i;

        if (p_rst) begin
            check("idle_req", o_req, 0);
            check("idle_valid", o_valid, 0);
        end else if (p_redir) begin
            check("flush_valid", o_valid, 0);
        end else if (p_valid && p_stall) begin
            check("hold_valid", o_valid, 1);
            check("hold_pc", o_pc, p_pc);
            check("hold_inst", o_inst, p_inst);
        end

        if (rst) begin
            q.delete();
            exp_pc = RST_PC;
        end else begin
            if (o_valid) begin
                if (q.size() == 0) begin
                    check("spurious_valid", o_valid, 0);
                end else begin
                    check("head_pc", o_pc, q[0]);
                    check("head_inst", o_inst, mem_word(q[0]));
                    if (!stall_i) void'(q.pop_front());
                end
            end else begin
                check("nop_inst", o_inst, NOP);
                check("nop_pc", o_pc, 0);
            end
            if (redirect_valid_i) begin
                check("redir_req", o_req, 0);
                q.delete();
                exp_pc = redirect_pc_i & 32'hFFFF_FFFC;
            end else if (o_grant) begin
                check("fetch_addr", o_addr, exp_pc);
                q.push_back(exp_pc);
                exp_pc = exp_pc + 32'd4;
            end
            check("occupancy", q.size() <= 2, 1);
        end

        last_grant = o_grant;
        last_addr  = o_addr;
        p_valid = o_valid;
        p_stall = stall_i;
        p_redir = redirect_valid_i;
        p_rst   = rst;
        p_pc    = o_pc;
        p_inst  = o_inst;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        d_stall = 1'b0;
        d_redir = 1'b0;
        d_gnt   = 1'b1;
        do begin
            step();
            n++;
        end while (!o_valid && n < 20);
        check({tag, "_seen"}, o_valid, 1);
    endtask

    initial begin
        bit seen_top, done;
        logic [31:0] hold_pc;
        int n;

        rst = 1'b1; stall_i = 1'b0; redirect_valid_i = 1'b0; redirect_pc_i = 32'd0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'd0;

        // reset release with a memory that always grants
        repeat (3) step();
        d_rst = 1'b0;
        step();
        check("rel_req0", o_req, 0);
        step();
        check("rel_req1", o_req, 1);
        check("rel_addr1", o_addr, RST_PC);
        step();
        check("rel_valid2", o_valid, 0);
        check("rel_addr2", o_addr, RST_PC + 32'd4);
        step();
        check("rel_valid3", o_valid, 1);
        check("rel_pc3", o_pc, RST_PC);
        repeat (6) step();

        // five-cycle stall in a steady stream
        d_stall = 1'b1;
        step();
        step();
        step();
        hold_pc = o_pc;
        check("stall_req", o_req, 0);
        check("stall_valid", o_valid, 1);
        step();
        check("stall_req_b", o_req, 0);
        step();
        check("stall_req_c", o_req, 0);
        check("stall_pc", o_pc, hold_pc);
        d_stall = 1'b0;
        repeat (8) step();

        // redirect to an unaligned target with a response in flight
        n = 0;
        do begin
            step();
            n++;
        end while (!o_grant && n < 10);
        check("pre_redir_grant", o_grant, 1);
        d_redir = 1'b1;
        d_tgt   = 32'h0000_3002;
        step();
        d_redir = 1'b0;
        step();
        check("redir_fetch_req", o_req, 1);
        check("redir_fetch_addr", o_addr, 32'h0000_3000);
        wait_valid("redir");
        check("redir_pc", o_pc, 32'h0000_3000);

        // redirect together with stall while the buffer is full
        d_stall = 1'b1;
        repeat (4) step();
        check("full_valid", o_valid, 1);
        check("full_req", o_req, 0);
        d_redir = 1'b1;
        d_tgt   = 32'h0000_4000;
        step();
        d_redir = 1'b0;
        step();
        check("redir_stall_valid", o_valid, 0);
        d_stall = 1'b0;
        wait_valid("after_flush");
        check("after_flush_pc", o_pc, 32'h0000_4000);

        // fetch address wraps past the top of the address space
        d_redir = 1'b1;
        d_tgt   = 32'hFFFF_FFF8;
        step();
        d_redir  = 1'b0;
        seen_top = 1'b0;
        done     = 1'b0;
        for (int i = 0; i < 15 && !done; i++) begin
            step();
            if (o_grant) begin
                if (seen_top) begin
                    check("wrap_addr", o_addr, 32'h0000_0000);
                    done = 1'b1;
                end else if (o_addr == 32'hFFFF_FFFC) begin
                    seen_top = 1'b1;
                end
            end
        end
        check("wrap_done", done, 1);
        repeat (4) step();

        // reset in the same cycle as a grant; its response lands after release
        rst_on_req = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!rst_hit && n < 10);
        check("rst_hit", rst_hit, 1);
        step();
        check("rst_resp_arrived", imem_rvalid_i, 1);
        wait_valid("post_rst");
        check("post_rst_pc", o_pc, RST_PC);
        check("post_rst_inst", o_inst, mem_word(RST_PC));

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            d_stall = ($urandom_range(9) < 3);
            d_gnt   = ($urandom_range(9) < 7);
            d_redir = ($urandom_range(19) == 0);
            d_tgt   = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15)) : $urandom;
            d_rst   = ($urandom_range(199) == 0);
            step();
        end
        d_rst = 1'b0;
        d_redir = 1'b0;
        d_stall = 1'b0;
        d_gnt = 1'b1;
        repeat (20) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
